// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_pkg
// Description : Shared types and constants for the SPI target bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

    // Frame decoder states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    // Default command bytes
    localparam logic [7:0] c_cmd_write_default = 8'h02;
    localparam logic [7:0] c_cmd_read_default  = 8'h03;

    // Default bus geometry: address bytes carried in each frame
    localparam int c_addr_width_default = 16;
    localparam int ADDR_BYTES           = c_addr_width_default / 8;

endpackage : spi_target_pkg
`default_nettype wire

// File: rtl/spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_sync
// Description : Multi-stage synchroniser with registered rise/fall pulses.
//               Pulses are suppressed until the pipeline holds only samples
//               taken after reset, so a pin already active at reset release
//               never produces a spurious edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic [SYNC_STAGES:0]   r_warm;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // Synchronise the pin and emit edge pulses one stage after the chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{IDLE_LEVEL}};
            r_warm  <= '0;
            r_level <= IDLE_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
            r_warm  <= {r_warm[SYNC_STAGES-1:0], 1'b1};
            r_level <= r_chain[SYNC_STAGES-1];
            r_rise  <= r_warm[SYNC_STAGES] &  r_chain[SYNC_STAGES-1] & ~r_level;
            r_fall  <= r_warm[SYNC_STAGES] & ~r_chain[SYNC_STAGES-1] &  r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule : spi_target_sync
`default_nettype wire

// File: rtl/spi_target_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_bridge
// Description : SPI mode-0 target giving an external initiator read/write
//               access to the 6502 system bus. Frame = command, address
//               (high byte first), then auto-incrementing data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target_bridge
    import spi_target_pkg::*;
#(
    parameter int         ADDR_WIDTH  = ADDR_BYTES * 8,
    parameter logic [7:0] CMD_WRITE   = c_cmd_write_default,
    parameter logic [7:0] CMD_READ    = c_cmd_read_default,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_mosi_i,
    input  logic                  spi_cs_ni,
    output logic                  spi_miso_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_wdata_o,
    output logic                  bus_we_o,
    output logic                  bus_re_o,
    input  logic [7:0]            bus_rdata_i,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int c_addr_bytes = ADDR_WIDTH / 8;

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_unused_sync;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic [7:0]            r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_acc;
    logic                  r_is_read;
    logic                  r_data_seen;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [7:0]            r_wdata;
    logic                  r_we;
    logic                  r_re;
    logic                  r_re_pend;
    logic                  r_re_d;
    logic                  r_inc_pend;
    logic [7:0]            r_tx;
    logic                  r_miso;
    logic                  r_done;

    logic [7:0]            w_byte;
    logic                  w_in_frame;
    logic                  w_byte_done;
    logic                  w_addr_last;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk_i), .rst(reset_i), .i_pin(spi_sclk_i),
        .o_level(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk_i), .rst(reset_i), .i_pin(spi_mosi_i),
        .o_level(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk_i), .rst(reset_i), .i_pin(spi_cs_ni),
        .o_level(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_unused_sync = ^{w_sclk_s, w_mosi_rise, w_mosi_fall};

    // MOSI is aligned with the rise pulse, so the completed byte is formed here
    assign w_byte      = {r_shift, w_mosi_s};
    assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                         (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA);
    assign w_byte_done = w_sclk_rise && w_in_frame && (r_bit_cnt == 3'd7);
    assign w_addr_last = (r_byte_cnt == 8'(c_addr_bytes - 1));
    assign w_addr_next = ADDR_WIDTH'({r_addr_acc, w_byte});

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state decode; CS release wins from any state
    always_comb begin
        w_next_state = r_state;
        if (w_cs_rise) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_next_state = ST_CMD;
                ST_CMD:
                    if (w_byte_done)
                        w_next_state = (w_byte == CMD_WRITE || w_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
                ST_ADDR:
                    if (w_byte_done && w_addr_last)
                        w_next_state = r_is_read ? ST_RD_DATA : ST_WR_DATA;
                default: w_next_state = r_state;
            endcase
        end
    end

    // Shifting, address assembly, bus strobes and read prefetch pipeline
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_addr_acc  <= '0;
            r_is_read   <= 1'b0;
            r_data_seen <= 1'b0;
            r_bus_addr  <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_re_pend   <= 1'b0;
            r_re_d      <= 1'b0;
            r_inc_pend  <= 1'b0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_re       <= r_re_pend;
            r_re_pend  <= 1'b0;
            r_inc_pend <= 1'b0;
            r_done     <= 1'b0;
            r_re_d     <= r_re;
            if (r_inc_pend) r_bus_addr <= r_bus_addr + ADDR_WIDTH'(1);

            if (w_cs_fall && r_state == ST_IDLE) begin
                r_bit_cnt   <= '0;
                r_shift     <= '0;
                r_byte_cnt  <= '0;
                r_data_seen <= 1'b0;
                r_miso      <= 1'b0;
            end

            if (w_cs_rise) begin
                r_done <= r_data_seen && (r_state != ST_IGNORE);
            end else begin
                if (w_sclk_rise && w_in_frame) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_sclk_fall && r_state == ST_RD_DATA) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: r_is_read <= (w_byte == CMD_READ);
                        ST_ADDR: begin
                            r_addr_acc <= w_addr_next;
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                            if (w_addr_last) begin
                                r_bus_addr <= w_addr_next;
                                r_re       <= r_is_read;
                            end
                        end
                        ST_WR_DATA: begin
                            r_wdata     <= w_byte;
                            r_we        <= 1'b1;
                            r_inc_pend  <= 1'b1;
                            r_data_seen <= 1'b1;
                        end
                        ST_RD_DATA: begin
                            r_bus_addr  <= r_bus_addr + ADDR_WIDTH'(1);
                            r_re_pend   <= 1'b1;
                            r_data_seen <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // Read data returns one cycle after the strobe; it always lands
            // before the next SCLK falling edge given the clock ratio
            if (r_re_d) r_tx <= bus_rdata_i;
        end
    end

    assign spi_miso_o   = r_miso && (r_state == ST_RD_DATA);
    assign bus_addr_o   = r_bus_addr;
    assign bus_wdata_o  = r_wdata;
    assign bus_we_o     = r_we;
    assign bus_re_o     = r_re;
    assign busy_o       = ~w_cs_s;
    assign frame_done_o = r_done;

endmodule : spi_target_bridge
`default_nettype wire

// File: tb/tb_spi_target_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_target_bridge
// Description : Directed, table-driven bench for spi_target_bridge with a
//               small bus memory model and strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target_bridge;
    import spi_target_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        miso;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdata = 8'h00;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [23:0] we_q[$];
    logic [15:0] re_q[$];
    int          done_cnt = 0;
    int          miso_hi  = 0;
    int          both_cnt = 0;

    spi_target_bridge #(.ADDR_WIDTH(16), .CMD_WRITE(8'h02), .CMD_READ(8'h03), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .spi_sclk_i(sclk), .spi_mosi_i(mosi), .spi_cs_ni(cs_n), .spi_miso_o(miso),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_we_o(bus_we), .bus_re_o(bus_re),
        .bus_rdata_i(bus_rdata), .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    // Bus memory model contents
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h00FF: return 8'h3C;
            16'h0100: return 8'hC3;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Read data is presented exactly one clock after the read strobe
    always @(posedge clk) begin
        if (bus_re) bus_rdata <= mem_rd(bus_addr);
    end

    // Record strobes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus_we)           we_q.push_back({bus_addr, bus_wdata});
        if (bus_re)           re_q.push_back(bus_addr);
        if (frame_done)       done_cnt = done_cnt + 1;
        if (miso)             miso_hi = miso_hi + 1;
        if (bus_we && bus_re) both_cnt = both_cnt + 1;
    end

    typedef struct {
        int              n;
        logic [5:0][7:0] tx;     // byte 0 is the rightmost element
        logic [5:0][7:0] rx;
        int              n_we;
        logic [1:0][23:0] we;    // {addr, data}
        int              n_re;
        logic [2:0][15:0] re;
        int              n_done;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 initiator: data set while SCLK low, MISO sampled on rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            clks(4);
            sclk  = 1'b1;
            rx[i] = miso;
            clks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_assert();
        cs_n = 1'b0;
        clks(8);
    endtask

    task automatic cs_release();
        clks(4);
        cs_n = 1'b1;
        clks(12);
    endtask

    function automatic logic [23:0] we_at(input int idx);
        if (idx < we_q.size()) return we_q[idx];
        return 24'hxxxxxx;
    endfunction

    function automatic logic [15:0] re_at(input int idx);
        if (idx < re_q.size()) return re_q[idx];
        return 16'hxxxx;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},  {31'd0, miso},       32'd0);
        check({tag, "_addr"},  {16'd0, bus_addr},   32'd0);
        check({tag, "_wdata"}, {24'd0, bus_wdata},  32'd0);
        check({tag, "_we_re"}, {30'd0, bus_we, bus_re}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          we0, re0, d0, m0;
        logic [7:0]  r;

        vecs[0] = '{n: 5, tx: {8'h00, 8'h55, 8'hAA, 8'h34, 8'h12, 8'h02}, rx: '0,
                    n_we: 2, we: {24'h123555, 24'h1234AA}, n_re: 0, re: '0, n_done: 1};
        vecs[1] = '{n: 5, tx: {8'h00, 8'h22, 8'h11, 8'hFF, 8'hFF, 8'h02}, rx: '0,
                    n_we: 2, we: {24'h000022, 24'hFFFF11}, n_re: 0, re: '0, n_done: 1};
        vecs[2] = '{n: 4, tx: {8'h00, 8'h00, 8'h03, 8'h02, 8'h01, 8'h55}, rx: '0,
                    n_we: 0, we: '0, n_re: 0, re: '0, n_done: 0};
        vecs[3] = '{n: 5, tx: {8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h03},
                    rx: {8'h00, 8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00},
                    n_we: 0, we: '0, n_re: 3, re: {16'h0101, 16'h0100, 16'h00FF}, n_done: 1};

        // Power-on reset
        clks(3);
        check_reset_outputs("por");
        reset_i = 1'b0;
        clks(6);

        // Table-driven full frames
        for (int v = 0; v < 4; v++) begin
            we0 = we_q.size(); re0 = re_q.size(); d0 = done_cnt; m0 = miso_hi;
            cs_assert();
            check($sformatf("v%0d_busy_hi", v), {31'd0, busy}, 32'd1);
            for (int b = 0; b < vecs[v].n; b++) begin
                spi_xfer(vecs[v].tx[b], 8, r);
                check($sformatf("v%0d_rx%0d", v, b), {24'd0, r}, {24'd0, vecs[v].rx[b]});
            end
            cs_release();
            check($sformatf("v%0d_busy_lo", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_we_cnt", v), we_q.size() - we0, vecs[v].n_we);
            for (int k = 0; k < vecs[v].n_we; k++)
                check($sformatf("v%0d_we%0d", v, k), {8'd0, we_at(we0 + k)}, {8'd0, vecs[v].we[k]});
            check($sformatf("v%0d_re_cnt", v), re_q.size() - re0, vecs[v].n_re);
            for (int k = 0; k < vecs[v].n_re; k++)
                check($sformatf("v%0d_re%0d", v, k), {16'd0, re_at(re0 + k)}, {16'd0, vecs[v].re[k]});
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].n_done);
            if (vecs[v].n_re == 0)
                check($sformatf("v%0d_miso_quiet", v), miso_hi - m0, 32'd0);
        end

        // Partial trailing byte is dropped
        we0 = we_q.size(); d0 = done_cnt;
        cs_assert();
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'h20, 8, r);
        spi_xfer(8'h00, 8, r);
        spi_xfer(8'hAB, 8, r);
        spi_xfer(8'hCD, 4, r);
        cs_release();
        check("partial_we_cnt", we_q.size() - we0, 32'd1);
        check("partial_we0", {8'd0, we_at(we0)}, {8'd0, 24'h2000AB});
        check("partial_done", done_cnt - d0, 32'd1);

        // Reset in the middle of the address phase, then a fresh frame
        we0 = we_q.size(); d0 = done_cnt;
        cs_assert();
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'h00, 4, r);
        reset_i = 1'b1;
        clks(1);
        check_reset_outputs("midrst");
        reset_i = 1'b0;
        clks(2);
        cs_n = 1'b1;
        clks(12);
        check("midrst_no_we", we_q.size() - we0, 32'd0);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        cs_assert();
        spi_xfer(8'h02, 8, r);
        spi_xfer(8'h00, 8, r);
        spi_xfer(8'h10, 8, r);
        spi_xfer(8'h77, 8, r);
        cs_release();
        check("midrst_we_cnt", we_q.size() - we0, 32'd1);
        check("midrst_we0", {8'd0, we_at(we0)}, {8'd0, 24'h001077});
        check("midrst_done", done_cnt - d0, 32'd1);

        check("we_re_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_target_bridge
`default_nettype wire

// File: doc/spi_target_bridge.md
Name: spi_target_bridge

Overview:
- SPI mode-0 target (responder) that lets an external SPI initiator read and write the 6502 system bus.
- It is the far-end counterpart of the SPI initiator that main_6502 drives toward the Ethernet device.
- SCLK, MOSI and CS_N are oversampled in the clk_i domain. Decoded frames become single-cycle bus write strobes and fixed-latency bus read strobes.

Parameters:
- ADDR_WIDTH, 16, bus address width; must be a multiple of 8; address bytes per frame = ADDR_WIDTH/8.
- CMD_WRITE, 8'h02, command byte that selects a write frame.
- CMD_READ, 8'h03, command byte that selects a read frame.
- SYNC_STAGES, 2, synchroniser depth for SCLK, MOSI and CS_N; minimum 2.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- spi_sclk_i  in  1  SPI clock, idles low (mode 0).
- spi_mosi_i  in  1  initiator data, sampled on SCLK rising edge.
- spi_cs_ni  in  1  chip select, active low.
- spi_miso_o  out  1  target data, updated after SCLK falling edge.
- bus_addr_o  out  ADDR_WIDTH  bus address.
- bus_wdata_o  out  8  bus write data.
- bus_we_o  out  1  one-cycle write strobe.
- bus_re_o  out  1  one-cycle read strobe.
- bus_rdata_i  in  8  read data, valid exactly 1 clk_i after bus_re_o.
- busy_o  out  1  high while CS is asserted (synchronised).
- frame_done_o  out  1  one-cycle pulse on CS deassertion after a complete, valid frame.

Behaviour:
- Reset values: spi_miso_o=0, bus_addr_o=0, bus_wdata_o=0, bus_we_o=0, bus_re_o=0, busy_o=0, frame_done_o=0. State goes to IDLE, bit counter to 0, synchroniser flops to idle levels (SCLK=0, CS_N=1).
- Edge detection runs on synchronised signals. The rise/fall pulse lags the pin by SYNC_STAGES+1 cycles.
- Clock constraint: f(SCLK) <= f(clk_i)/8. For example, 12 MHz clk_i allows SCLK up to 1.5 MHz.
- Frame format, MSB first:
  - Byte 0: command.
  - Bytes 1..ADDR_WIDTH/8: address, high byte first.
  - Remaining bytes: data, with the address auto-incrementing after each data byte.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
- IDLE -> CMD on CS falling edge. The bit counter clears and the shift register clears.
- CMD -> ADDR after 8 bits when the byte equals CMD_WRITE or CMD_READ. Any other byte -> IGNORE.
- ADDR -> WR_DATA or RD_DATA after the last address bit. The address loads into bus_addr_o.
- On entry to RD_DATA:
  - bus_re_o pulses in the cycle after the last address rising edge.
  - bus_rdata_i is captured into the TX shift register one cycle later.
  - The MSB drives spi_miso_o on the next SCLK falling edge.
- WR_DATA, after each 8th rising edge:
  - bus_wdata_o gets the received byte, and bus_we_o pulses for 1 cycle using the current bus_addr_o.
  - bus_addr_o increments on the following cycle.
- RD_DATA, at each 8th rising edge:
  - bus_addr_o increments, then bus_re_o pulses one cycle later, prefetching the next byte.
  - The prefetched byte loads into the TX register before the next falling edge.
- Address arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF increments to 16'h0000.
- IGNORE: no bus strobes; spi_miso_o=0 until CS rises.
- spi_miso_o is 0 whenever CS is deasserted and during CMD, ADDR, WR_DATA and IGNORE.
- CS deasserted (any state) returns the FSM to IDLE:
  - A partial byte is discarded, and no strobe is issued for it.
  - frame_done_o pulses only if at least one complete data byte was transferred and the state was not IGNORE.
- CS falling while already in a frame cannot occur; a glitch shorter than the synchroniser is filtered by construction.
- reset_i mid-frame aborts immediately to reset values. The next frame is recognised only after a fresh CS falling edge.
- bus_we_o and bus_re_o are never asserted in the same cycle.

Decomposition:
- Package spi_target_pkg holds:
  - the state enum (state_t);
  - the default command constants;
  - localparam ADDR_BYTES = ADDR_WIDTH/8.
- Sub-module spi_target_sync: SYNC_STAGES-deep synchroniser plus rise/fall pulse generator. It is instanced once per input and emits sclk_rise, sclk_fall, cs_fall, cs_rise and mosi_s.

Test Plan:
- Write 02 12 34 AA 55 at SCLK=clk/8 -> bus_we_o pulses twice: (1234, AA) then (1235, 55); frame_done_o=1 after CS rises.
- Read 03 00 FF, then 2 dummy bytes, with the model returning mem[00FF]=3C and mem[0100]=C3 -> MISO bytes 3C, C3; bus_re_o addresses 00FF, 0100, 0101 (prefetch).
- Write 02 FF FF 11 22 -> writes at FFFF=11 and 0000=22 (wrap).
- Command 55 followed by 3 bytes -> no bus strobes, MISO held 0, frame_done_o stays 0.
- Write 02 20 00 AB, with CS raised after 4 bits of a second data byte -> exactly one write (2000, AB); partial byte dropped.
- reset_i asserted for 1 cycle during an address byte, then a new frame 02 00 10 77 -> all outputs at reset values during reset, then a single write (0010, 77).
